// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU layer types, datapath widths and the tile command record
package npu_pkg;

    localparam int CH_W  = 11;
    localparam int PIX_W = 14;

    typedef enum logic [1:0] {
        LT_PW  = 2'd0,
        LT_DW  = 2'd1,
        LT_STD = 2'd2,
        LT_LIN = 2'd3
    } layer_type_e;

    typedef struct packed {
        logic [CH_W-1:0]  k_base;
        logic [6:0]       k_len;
        logic [CH_W-1:0]  d_base;
        logic [6:0]       d_len;
        logic [PIX_W-1:0] p_base;
        logic [PIX_W-1:0] p_len;
        logic             first_d;
        logic             last_d;
        logic             last;
    } tile_cmd_t;

endpackage

// File: rtl/tile_loop_counter.sv
// tile_loop_counter: one loop level of the tile nest (running base, clipped length, last flag)
module tile_loop_counter #(
    parameter int W      = 11,
    parameter int STEP_W = 7,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    input  logic [STEP_W-1:0] step,
    input  logic [W-1:0]      bound,
    output logic [W-1:0]      base,
    output logic [LEN_W-1:0]  len,
    output logic              last
);

    // One bit wider than the widest operand so base+step can never wrap
    localparam int SW = (W > STEP_W ? W : STEP_W) + 1;

    logic [SW-1:0] stp, rem, sum;

    assign stp  = SW'(step);
    assign rem  = SW'(bound - base);
    assign sum  = SW'(base) + stp;
    assign last = sum >= SW'(bound);
    assign len  = LEN_W'(stp < rem ? stp : rem);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            base <= '0;
        else if (clr)
            base <= '0;
        else if (adv)
            base <= last ? '0 : sum[W-1:0];

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks the K / pixel / D tile nest of one layer and issues tile commands
module tile_scheduler
    import npu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       layer_type_i,
    input  logic [CH_W-1:0]  in_D_i,
    input  logic [CH_W-1:0]  out_K_i,
    input  logic [6:0]       out_R_i,
    input  logic [6:0]       out_C_i,
    input  logic [31:0]      tile_n_i,
    input  logic [6:0]       tile_D_i,
    input  logic [6:0]       tile_K_i,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [CH_W-1:0]  cmd_k_base_o,
    output logic [6:0]       cmd_k_len_o,
    output logic [CH_W-1:0]  cmd_d_base_o,
    output logic [6:0]       cmd_d_len_o,
    output logic [PIX_W-1:0] cmd_p_base_o,
    output logic [PIX_W-1:0] cmd_p_len_o,
    output logic             cmd_first_d_o,
    output logic             cmd_last_d_o,
    output logic             cmd_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_e;

    state_e           state;
    layer_type_e      lt;
    logic [CH_W-1:0]  in_d, out_k, k_base, d_base;
    logic [6:0]       out_r, out_c, tile_d, tile_k, k_len, d_len;
    logic [31:0]      tile_n;
    logic [PIX_W-1:0] p_total, p_base, p_len;
    logic             valid, busy, done, err;
    logic             k_last, p_last, d_last;
    tile_cmd_t        cmd;

    wire load       = state == LOAD;
    wire dw         = lt == LT_DW;
    wire d_last_eff = dw | d_last;
    wire cmd_last   = k_last & p_last & d_last_eff;
    wire hs         = valid & cmd_ready_i;
    wire bad_geom   = in_d == '0 || out_k == '0 || out_r == '0 || out_c == '0 ||
                      tile_n == '0 || tile_d == '0 || tile_k == '0;

    // Depthwise layers have no D loop: the pixel level advances on every handshake
    tile_loop_counter #(.W(CH_W), .STEP_W(7), .LEN_W(7)) u_k (
        .clk(clk), .rst_n(rst_n), .clr(load), .adv(hs & d_last_eff & p_last),
        .step(tile_k), .bound(out_k), .base(k_base), .len(k_len), .last(k_last)
    );

    tile_loop_counter #(.W(PIX_W), .STEP_W(32), .LEN_W(PIX_W)) u_p (
        .clk(clk), .rst_n(rst_n), .clr(load), .adv(hs & d_last_eff),
        .step(tile_n), .bound(p_total), .base(p_base), .len(p_len), .last(p_last)
    );

    tile_loop_counter #(.W(CH_W), .STEP_W(7), .LEN_W(7)) u_d (
        .clk(clk), .rst_n(rst_n), .clr(load), .adv(hs & ~dw),
        .step(tile_d), .bound(in_d), .base(d_base), .len(d_len), .last(d_last)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            lt      <= LT_PW;
            in_d    <= '0;
            out_k   <= '0;
            out_r   <= '0;
            out_c   <= '0;
            tile_n  <= '0;
            tile_d  <= '0;
            tile_k  <= '0;
            p_total <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (start_i) begin
                        lt     <= layer_type_e'(layer_type_i);
                        in_d   <= in_D_i;
                        out_k  <= out_K_i;
                        out_r  <= out_R_i;
                        out_c  <= out_C_i;
                        tile_n <= tile_n_i;
                        tile_d <= tile_D_i;
                        tile_k <= tile_K_i;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                LOAD: begin
                    p_total <= PIX_W'(out_r) * PIX_W'(out_c);
                    if (bad_geom) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        valid <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE:
                    if (hs && cmd_last) begin
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end

    // Fields read as zero whenever no command is offered
    always_comb begin
        cmd = '0;
        if (valid) begin
            cmd.k_base  = k_base;
            cmd.k_len   = k_len;
            cmd.d_base  = dw ? k_base : d_base;
            cmd.d_len   = dw ? k_len : d_len;
            cmd.p_base  = p_base;
            cmd.p_len   = p_len;
            cmd.first_d = dw | (d_base == '0);
            cmd.last_d  = d_last_eff;
            cmd.last    = cmd_last;
        end
    end

    assign cmd_valid_o   = valid;
    assign cmd_k_base_o  = cmd.k_base;
    assign cmd_k_len_o   = cmd.k_len;
    assign cmd_d_base_o  = cmd.d_base;
    assign cmd_d_len_o   = cmd.d_len;
    assign cmd_p_base_o  = cmd.p_base;
    assign cmd_p_len_o   = cmd.p_len;
    assign cmd_first_d_o = cmd.first_d;
    assign cmd_last_d_o  = cmd.last_d;
    assign cmd_last_o    = cmd.last;
    assign busy_o        = busy;
    assign done_o        = done;
    assign err_o         = err;

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Downstream of the layer decoder.
- Once per layer it takes the decoded geometry (channels, tile sizes, output dims, tile_n) and walks the tile loop nest.
- It emits one tile command per tile over a valid/ready handshake to the DMA/PE-array controller.
- Loop order: K-tile outer, spatial (pixel) tile middle, D-tile inner, so partial sums accumulate per spatial tile. No dividers are used; all bounds come from running bases and remainders.

Parameters:
- PIX_W, 14, width of the pixel index; holds out_R*out_C up to 127*127.
- CH_W, 11, channel index width; matches in_D/out_K.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse; decoded parameters valid this cycle
- layer_type_i  in  2  0=PW, 1=DW, 2=STD, 3=LIN
- in_D_i  in  CH_W  input channels
- out_K_i  in  CH_W  output channels
- out_R_i  in  7  ofmap rows
- out_C_i  in  7  ofmap cols
- tile_n_i  in  32  max pixels per spatial tile
- tile_D_i  in  7  input-channel tile size
- tile_K_i  in  7  output-channel tile size
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  consumer accepts command
- cmd_k_base_o  out  CH_W  first output channel of tile
- cmd_k_len_o  out  7  output channels in tile
- cmd_d_base_o  out  CH_W  first input channel of tile
- cmd_d_len_o  out  7  input channels in tile
- cmd_p_base_o  out  PIX_W  first linear output pixel
- cmd_p_len_o  out  PIX_W  pixels in tile
- cmd_first_d_o  out  1  first D-tile: init psum with bias
- cmd_last_d_o  out  1  last D-tile: quantize/write ofmap
- cmd_last_o  out  1  last command of layer
- busy_o  out  1  not IDLE
- done_o  out  1  one-cycle pulse at layer end
- err_o  out  1  sticky until next accepted start; illegal geometry

Behaviour:
- Reset: all outputs 0, FSM = IDLE, all counters 0. Reset asserted mid-layer aborts immediately; no further commands are issued.
- FSM states: IDLE, LOAD, ISSUE, DONE.
- IDLE: on start_i, latch all inputs, clear err_o, go to LOAD. start_i in any other state is ignored.
- LOAD (1 cycle):
  - Register P = out_R*out_C (PIX_W bits); clear k_base, p_base, d_base.
  - If any of in_D, out_K, out_R, out_C, tile_n, tile_D, tile_K is 0: set err_o and go to DONE. No commands are issued.
  - Otherwise go to ISSUE.
- Latency: first cmd_valid_o is 2 cycles after start_i.
- ISSUE:
  - cmd_valid_o = 1. All cmd fields come from registers and stay stable while valid && !ready.
  - Field lengths:
    - k_len = min(tile_K, out_K-k_base)
    - d_len = min(tile_D, in_D-d_base)
    - p_len = min(tile_n, P-p_base); the compare is 32-bit, the result fits in PIX_W.
  - Flags:
    - first_d = (d_base==0)
    - last_d = (d_base+tile_D >= in_D)
    - cmd_last = last_k && last_p && last_d
  - On handshake (valid && ready), advance the counters:
    - If !last_d: d_base += tile_D.
    - Else d_base = 0, then:
      - if !last_p: p_base += tile_n;
      - else p_base = 0 and k_base += tile_K.
  - Back-to-back: one command per cycle when ready is held high.
  - Handshake on cmd_last goes to DONE.
- DW (layer_type 1):
  - No D loop. d_base = k_base, d_len = k_len.
  - first_d = last_d = 1. Order is K outer, P inner.
- DONE: done_o = 1 for one cycle, cmd_valid_o = 0, then IDLE.
- Widths: base additions are computed 1 bit wider than their operands to prevent wrap; the "last" compares use the widened sum.

Decomposition:
- Shared package `npu_pkg`:
  - layer_type enum (PW/DW/STD/LIN)
  - CH_W and PIX_W constants
  - the tile_cmd_t struct (k/d/p base+len plus flags), reused by the DMA controller.
- One natural sub-module, `tile_loop_counter`: base register, min-length, last-flag and advance logic. Instantiate it three times (K, P, D).

Test Plan:
- PW, in_D=64, out_K=64, tile_D=tile_K=32, out_R=out_C=4 (P=16), tile_n=8, ready held 1:
  - 8 commands on consecutive cycles, order (k,p,d) = (0,0,0),(0,0,32),(0,8,0),(0,8,32),(32,0,0),…
  - first_d/last_d alternate.
  - cmd_last only on the 8th command; done_o exactly 1 cycle later.
- Remainders: in_D=40, tile_D=32, out_K=10, tile_K=32, P=10, tile_n=8:
  - d_len 32 then 8; p_len 8 then 2; k_len 10; 4 commands total.
- DW: out_K=20, tile_K=10, P=4, tile_n=4:
  - 2 commands with d_base=k_base ∈ {0,10}, first_d=last_d=1.
- Backpressure: randomly drop cmd_ready_i:
  - fields are held stable while stalled;
  - no command is skipped or duplicated;
  - sequence is identical to the ready=1 run.
- Error: start with tile_n_i=0:
  - no cmd_valid_o;
  - err_o=1, done_o pulses 2 cycles after start;
  - the next valid start clears err_o.
- Reset: assert rst_n=0 during the 3rd command stall:
  - all outputs 0 immediately, FSM in IDLE;
  - a new start then issues the full sequence from command 0.
